simd_mp_top: RTL and testbench

//  Top level of the SIMD multiprocessor: a command issuer pops vector commands from an external FIFO.
//  It dispatches each command to a pool of vector processing elements (PEs) sharing one data memory.

---
 rtl/simd_pkg.sv | 53 +++++
 rtl/pe_pool.sv | 132 +++++++++++++
 rtl/shared_mem.sv | 50 +++++
 rtl/simd_mp_top.sv | 110 +++++++++++
 tb/tb_simd_mp_top.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: shared types and constants for the SIMD multiprocessor.
//   MEM_SIZE  shared-memory depth in words; macro MEM_SIZE overrides the default of 256.
//             Must be a power of two, because address arithmetic wraps at ADDR_W bits.
//   cmd_t     packed vector command {op, dst, src_a, src_b, len}.
//   ranges_overlap  circular-range intersection test, used by the hazard check.
`ifndef MEM_SIZE
`define MEM_SIZE 256
`endif

package simd_pkg;

  localparam int MEM_SIZE = `MEM_SIZE;
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int N_PE   = 2;
  localparam int PE_W   = (N_PE > 1) ? $clog2(N_PE) : 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_COPY = 2'd3
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic {ISS_IDLE, ISS_CHECK} iss_state_e;
  typedef enum logic {PE_IDLE, PE_RUN} pe_state_e;

  // Two circular ranges intersect exactly when the start of one of them
  // lies inside the other. Distances are taken modulo MEM_SIZE.
  function automatic logic ranges_overlap(input logic [ADDR_W-1:0] base_a,
                                          input logic [LEN_W-1:0]  len_a,
                                          input logic [ADDR_W-1:0] base_b,
                                          input logic [LEN_W-1:0]  len_b);
    logic [ADDR_W-1:0] d_ab;
    logic [ADDR_W-1:0] d_ba;
    d_ab = base_b - base_a;
    d_ba = base_a - base_b;
    return (len_a != '0) && (len_b != '0) &&
           ((32'(d_ab) < 32'(len_a)) || (32'(d_ba) < 32'(len_b)));
  endfunction

endpackage

// File: rtl/pe_pool.sv
// pe_pool: N_PE vector processing elements plus a round-robin memory arbiter.
//   Macro HAZARD_CHECK_EN: when defined, a candidate command conflicts only with busy PEs whose
//   ranges overlap it (RAW/WAW/WAR). When undefined, any busy PE is a conflict, which fully
//   serialises the pool.
// Ports: i_clk, i_rst (sync, active-high); disp_valid/disp_pe/cand_cmd (dispatch from the issuer);
//   pe_busy (per-PE RUN flag); conflict (candidate may not start now);
//   rd_addr_a/rd_addr_b/rd_data_a/rd_data_b, wr_en/wr_addr/wr_data (shared memory ports).
//
// state   | meaning
// PE_IDLE | free; accepts a dispatched command
// PE_RUN  | one element per memory grant; leaves after the last element is written
module pe_pool
  import simd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              disp_valid,
  input  logic [PE_W-1:0]   disp_pe,
  input  cmd_t              cand_cmd,
  output logic [N_PE-1:0]   pe_busy,
  output logic              conflict,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  pe_state_e        state_q [N_PE];
  pe_state_e        state_d [N_PE];
  logic [LEN_W-1:0] idx_q   [N_PE];
  logic [LEN_W-1:0] idx_d   [N_PE];
  cmd_t             cmd_q   [N_PE];
  logic [PE_W-1:0]  rr_q, rr_d, gnt_pe;
  logic             gnt_valid;
  cmd_t             g_cmd;
  logic [LEN_W-1:0] g_idx;

  // Rotating-priority arbiter: search starts at rr_q, which moves past each winner.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_pe    = rr_q;
    for (int k = 0; k < N_PE; k++) begin
      cand = (int'(rr_q) + k) % N_PE;
      if (!gnt_valid && state_q[cand] == PE_RUN) begin
        gnt_valid = 1'b1;
        gnt_pe    = PE_W'(cand);
      end
    end
    rr_d = rr_q;
    if (gnt_valid) rr_d = PE_W'((int'(gnt_pe) + 1) % N_PE);
  end

  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      state_d[p] = state_q[p];
      idx_d[p]   = idx_q[p];
      pe_busy[p] = (state_q[p] == PE_RUN);
      case (state_q[p])
        PE_IDLE: begin
          if (disp_valid && disp_pe == PE_W'(p)) begin
            state_d[p] = PE_RUN;
            idx_d[p]   = '0;
          end
        end
        PE_RUN: begin
          if (gnt_valid && gnt_pe == PE_W'(p)) begin
            if (idx_q[p] == cmd_q[p].len - LEN_W'(1)) state_d[p] = PE_IDLE;
            else idx_d[p] = idx_q[p] + LEN_W'(1);
          end
        end
        default: state_d[p] = PE_IDLE;
      endcase
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < N_PE; p++) begin
      if (state_q[p] == PE_RUN) begin
`ifdef HAZARD_CHECK_EN
        if (ranges_overlap(cand_cmd.src_a, cand_cmd.len, cmd_q[p].dst,   cmd_q[p].len) ||
            ranges_overlap(cand_cmd.src_b, cand_cmd.len, cmd_q[p].dst,   cmd_q[p].len) ||
            ranges_overlap(cand_cmd.dst,   cand_cmd.len, cmd_q[p].dst,   cmd_q[p].len) ||
            ranges_overlap(cand_cmd.dst,   cand_cmd.len, cmd_q[p].src_a, cmd_q[p].len) ||
            ranges_overlap(cand_cmd.dst,   cand_cmd.len, cmd_q[p].src_b, cmd_q[p].len))
          conflict = 1'b1;
`else
        conflict = 1'b1;
`endif
      end
    end
  end

  // Datapath for the granted PE: read both operands and write the result in one cycle.
  always_comb begin
    g_cmd     = cmd_q[gnt_pe];
    g_idx     = idx_q[gnt_pe];
    rd_addr_a = g_cmd.src_a + ADDR_W'(g_idx);
    rd_addr_b = g_cmd.src_b + ADDR_W'(g_idx);
    wr_addr   = g_cmd.dst + ADDR_W'(g_idx);
    wr_en     = gnt_valid;
    case (g_cmd.op)
      OP_ADD:  wr_data = rd_data_a + rd_data_b;
      OP_SUB:  wr_data = rd_data_a - rd_data_b;
      OP_MUL:  wr_data = DATA_W'(rd_data_a * rd_data_b);
      default: wr_data = rd_data_a;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q <= '0;
      for (int p = 0; p < N_PE; p++) begin
        state_q[p] <= PE_IDLE;
        idx_q[p]   <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int p = 0; p < N_PE; p++) begin
        state_q[p] <= state_d[p];
        idx_q[p]   <= idx_d[p];
      end
    end
    for (int p = 0; p < N_PE; p++) begin
      if (disp_valid && disp_pe == PE_W'(p)) cmd_q[p] <= cand_cmd;
    end
  end
endmodule

// File: rtl/shared_mem.sv
// shared_mem: shared data memory, 2 asynchronous read ports + 1 synchronous write port.
//   The storage lives in instance u_mem (array r_mem), so a bench can load and dump it directly.
//   Contents are not reset. A read of an address in the same cycle that address is written
//   returns the old word.
// Ports: i_clk, we/waddr/wdata (write port), raddr_a/raddr_b -> rdata_a/rdata_b (read ports).
module shared_mem_array
  import simd_pkg::*;
(
  input  logic              i_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] r_mem [MEM_SIZE];

  always_ff @(posedge i_clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];
endmodule

module shared_mem
  import simd_pkg::*;
(
  input  logic              i_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  shared_mem_array u_mem (
    .i_clk   (i_clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );
endmodule

// File: rtl/simd_mp_top.sv
// simd_mp_top: SIMD multiprocessor top. The issuer pops vector commands from an external
//   first-word-fall-through FIFO and dispatches them, in strict order, to a pool of PEs sharing
//   one data memory.
//   Macro HAZARD_CHECK_EN (consumed in pe_pool) lets non-overlapping commands run concurrently.
//   Macro MEM_SIZE (consumed in simd_pkg) overrides the memory depth.
// Ports: i_clk; i_rst (sync, active-high); queue_cmd/queue_empty (FIFO head);
//   issuer_rd_queue (1-cycle pop strobe);
//   finished_task (FIFO empty, issuer idle and all PEs idle).
//
// state     | meaning
// ISS_IDLE  | waiting for a command; pops the FIFO head when one is present
// ISS_CHECK | holding a popped command until it can be dispatched (stalls here)
module simd_mp_top
  import simd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CMD_W-1:0] queue_cmd,
  input  logic             queue_empty,
  output logic             issuer_rd_queue,
  output logic             finished_task
);
  iss_state_e        state_q, state_d;
  cmd_t              cmd_q;
  logic              ft_q;
  logic [N_PE-1:0]   pe_busy;
  logic              conflict, free_valid, disp_valid;
  logic [PE_W-1:0]   free_pe;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;
  logic              wr_en;

  // Lowest-index idle PE.
  always_comb begin
    free_valid = 1'b0;
    free_pe    = '0;
    for (int p = N_PE - 1; p >= 0; p--) begin
      if (!pe_busy[p]) begin
        free_valid = 1'b1;
        free_pe    = PE_W'(p);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    issuer_rd_queue = 1'b0;
    disp_valid      = 1'b0;
    case (state_q)
      ISS_IDLE: begin
        if (!queue_empty && !i_rst) begin
          issuer_rd_queue = 1'b1;
          state_d         = ISS_CHECK;
        end
      end
      ISS_CHECK: begin
        // Zero-length commands touch no memory, so they retire without a PE.
        if (cmd_q.len == '0) begin
          state_d = ISS_IDLE;
        end else if (free_valid && !conflict) begin
          disp_valid = 1'b1;
          state_d    = ISS_IDLE;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ISS_IDLE;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ft_q    <= queue_empty && (state_q == ISS_IDLE) && (pe_busy == '0);
    end
    if (issuer_rd_queue) cmd_q <= cmd_t'(queue_cmd);
  end

  // The queue_empty term drops the flag in the very cycle new work shows up.
  assign finished_task = ft_q && queue_empty && !i_rst;

  pe_pool u_pool (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .disp_valid (disp_valid),
    .disp_pe    (free_pe),
    .cand_cmd   (cmd_q),
    .pe_busy    (pe_busy),
    .conflict   (conflict),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  shared_mem u_shared_mem (
    .i_clk   (i_clk),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b)
  );
endmodule

// File: tb/tb_simd_mp_top.sv
// Directed testbench for simd_mp_top: FIFO model, memory backdoor, hand-computed results.
module tb_simd_mp_top;
  import simd_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [CMD_W-1:0] queue_cmd = '0;
  logic             queue_empty = 1'b1;
  logic             issuer_rd_queue;
  logic             finished_task;

  int   checks = 0;
  int   failures = 0;
  logic last_pop = 1'b0;
  cmd_t fifo[$];

  simd_mp_top dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .queue_cmd       (queue_cmd),
    .queue_empty     (queue_empty),
    .issuer_rd_queue (issuer_rd_queue),
    .finished_task   (finished_task)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input op_e op, input int dst, input int a, input int b, input int len);
    cmd_t c;
    c.op    = op;
    c.dst   = ADDR_W'(dst);
    c.src_a = ADDR_W'(a);
    c.src_b = ADDR_W'(b);
    c.len   = LEN_W'(len);
    return c;
  endfunction

  task automatic drive();
    queue_empty = (fifo.size() == 0);
    queue_cmd   = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // One clock: sample the pop strobe mid-cycle, then update the FIFO just after the edge.
  task automatic step();
    @(negedge i_clk);
    last_pop = issuer_rd_queue;
    @(posedge i_clk);
    #1;
    if (last_pop && fifo.size() != 0) void'(fifo.pop_front());
    drive();
  endtask

  task automatic wr(input int a, input logic [31:0] v);
    dut.u_shared_mem.u_mem.r_mem[ADDR_W'(a)] <= v;
  endtask

  function automatic logic [31:0] rd(input int a);
    return dut.u_shared_mem.u_mem.r_mem[ADDR_W'(a)];
  endfunction

  task automatic wait_done(input string tag, output int max_busy);
    int n;
    n = 0;
    max_busy = 0;
    do begin
      step();
      n++;
      if ($countones(dut.u_pool.pe_busy) > max_busy) max_busy = $countones(dut.u_pool.pe_busy);
    end while (finished_task !== 1'b1 && n < 500);
    chk({tag, "_done"}, 32'(finished_task), 32'd1);
  endtask

  initial begin
    int mb;
    int exp_mb;

    // Reset with a command already waiting: nothing may be popped.
    fifo.push_back(mk(OP_ADD, 32, 0, 16, 4));
    drive();
    i_rst = 1'b1;
    repeat (3) step();
    chk("rst_rd_queue", 32'(last_pop), 32'd0);
    chk("rst_finished", 32'(finished_task), 32'd0);
    chk("rst_pe_busy", 32'(dut.u_pool.pe_busy), 32'd0);
    fifo.delete();
    drive();
    i_rst = 1'b0;
    step();
    chk("rel_finished", 32'(finished_task), 32'd1);

    // Memory image
    for (int i = 0; i < 8; i++) begin
      wr(i, 32'(i + 1));
      wr(16 + i, 32'(10 * (i + 1)));
      wr(32 + i, 32'hDEAD);
      wr(64 + i, 32'hEEEE);
    end
    #1;

    // Single ADD with latency check
    fifo.push_back(mk(OP_ADD, 32, 0, 16, 4));
    drive();
    #1;
    chk("ft_drop_on_cmd", 32'(finished_task), 32'd0);
    step();
    chk("add_pop", 32'(last_pop), 32'd1);
    chk("add_pre_write0", rd(32), 32'hDEAD);
    step();
    chk("add_pre_write1", rd(32), 32'hDEAD);
    step();
    chk("add_first_write", rd(32), 32'd11);
    wait_done("add", mb);
    for (int i = 0; i < 4; i++) chk($sformatf("add_m%0d", 32 + i), rd(32 + i), 32'(11 * (i + 1)));

    // SUB / MUL wrap, COPY
    wr(40, 32'd0); wr(41, 32'd1); wr(42, 32'd0);
    wr(43, 32'h10000); wr(44, 32'd5);
    wr(45, 32'h1234); wr(46, 32'h9999); wr(47, 32'd0); wr(48, 32'h4848);
    #1;
    fifo.push_back(mk(OP_SUB, 42, 40, 41, 1));
    fifo.push_back(mk(OP_MUL, 44, 43, 43, 1));
    fifo.push_back(mk(OP_COPY, 47, 45, 46, 1));
    drive();
    wait_done("ops", mb);
    chk("sub_wrap", rd(42), 32'hFFFF_FFFF);
    chk("mul_wrap", rd(44), 32'h0);
    chk("copy_a", rd(47), 32'h1234);
    chk("copy_len1", rd(48), 32'h4848);

    // RAW chain: second command consumes the first one's results
    fifo.push_back(mk(OP_ADD, 64, 0, 16, 4));
    fifo.push_back(mk(OP_ADD, 80, 64, 16, 4));
    drive();
    wait_done("raw", mb);
    for (int i = 0; i < 4; i++) chk($sformatf("raw_m%0d", 80 + i), rd(80 + i), 32'(21 * (i + 1)));
    chk("raw_max_busy", 32'(mb), 32'd1);

    // Independent commands
    fifo.push_back(mk(OP_ADD, 100, 0, 16, 8));
    fifo.push_back(mk(OP_SUB, 120, 16, 0, 8));
    drive();
    wait_done("indep", mb);
    chk("indep_m100", rd(100), 32'd11);
    chk("indep_m107", rd(107), 32'd88);
    chk("indep_m120", rd(120), 32'd9);
    chk("indep_m127", rd(127), 32'd72);
`ifdef HAZARD_CHECK_EN
    exp_mb = 2;
`else
    exp_mb = 1;
`endif
    chk("indep_max_busy", 32'(mb), 32'(exp_mb));

    // len == 0: popped, memory untouched
    wr(200, 32'h77);
    #1;
    fifo.push_back(mk(OP_ADD, 200, 0, 16, 0));
    drive();
    wait_done("len0", mb);
    chk("len0_mem", rd(200), 32'h77);
    chk("len0_popped", 32'(fifo.size()), 32'd0);

    // Reset in the middle of a RUN
    for (int i = 0; i < 8; i++) wr(150 + i, 32'hBEEF);
    #1;
    fifo.push_back(mk(OP_ADD, 150, 16, 16, 8));
    drive();
    repeat (4) step();
    fifo.push_back(mk(OP_ADD, 160, 0, 0, 2));
    drive();
    i_rst = 1'b1;
    step();
    chk("midrst_rd_queue", 32'(last_pop), 32'd0);
    chk("midrst_finished", 32'(finished_task), 32'd0);
    chk("midrst_pe_busy", 32'(dut.u_pool.pe_busy), 32'd0);
    chk("midrst_partial", rd(150), 32'd20);
    chk("midrst_untouched", rd(157), 32'hBEEF);
    fifo.delete();
    drive();
    i_rst = 1'b0;
    step();
    chk("midrst_rel_finished", 32'(finished_task), 32'd1);

    // Address wrap
    for (int i = 0; i < 4; i++) begin
      wr(8 + i, 32'(100 + i));
      wr(24 + i, 32'(2 * i));
    end
    wr(253, 32'h55); wr(2, 32'hAA);
    wr(254, 32'd0); wr(255, 32'd0); wr(0, 32'd0); wr(1, 32'd0);
    #1;
    fifo.push_back(mk(OP_ADD, MEM_SIZE - 2, 8, 24, 4));
    drive();
    wait_done("wrap", mb);
    chk("wrap_m254", rd(MEM_SIZE - 2), 32'd100);
    chk("wrap_m255", rd(MEM_SIZE - 1), 32'd103);
    chk("wrap_m0", rd(0), 32'd106);
    chk("wrap_m1", rd(1), 32'd109);
    chk("wrap_below", rd(MEM_SIZE - 3), 32'h55);
    chk("wrap_above", rd(2), 32'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
